phys_reg_allocator: RTL and testbench

//  Owns the physical register pool shared by rename and the out-of-order issue buffer.

---
 rtl/phys_reg_allocator_pkg.sv | 22 ++
 rtl/phys_reg_allocator_ckpt_ring.sv | 78 +++++++
 rtl/phys_reg_allocator.sv | 95 +++++++++
 tb/tb_phys_reg_allocator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_allocator_pkg.sv
// Shared types and sizing for the physical register allocator.
package phys_reg_allocator_pkg;

   localparam int unsigned NUM_PHYS_REGS = 64;
   localparam int unsigned NUM_ARCH_REGS = 32;
   localparam int unsigned NUM_CKPTS     = 4;

   // Free FIFO holds every preg not mapped at reset.
   localparam int unsigned FREE_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

   localparam int unsigned PREG_W     = $clog2(NUM_PHYS_REGS);
   localparam int unsigned CKPT_W     = $clog2(NUM_CKPTS);
   localparam int unsigned FIFO_IDX_W = $clog2(FREE_DEPTH);

   typedef logic [PREG_W-1:0]   PhysReg;
   typedef logic [CKPT_W-1:0]   CkptId;
   // Free FIFO pointer: index plus wrap bit, so tail-head is the occupancy.
   typedef logic [FIFO_IDX_W:0] FreePtr;
   // Checkpoint occupancy: 0..NUM_CKPTS inclusive.
   typedef logic [CKPT_W:0]     CkptCnt;

endpackage

// File: rtl/phys_reg_allocator_ckpt_ring.sv
// Branch checkpoint ring: stores free-FIFO head snapshots and truncates on recovery.
module phys_reg_allocator_ckpt_ring
   import phys_reg_allocator_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   ckpt_req,
   input  logic   ckpt_retire,
   input  logic   recover_valid,
   input  CkptId  recover_id,
   input  FreePtr snap_head,
   output logic   ckpt_ack,
   output CkptId  ckpt_id,
   output logic   ckpt_full,
   output FreePtr recover_head
);

   CkptId  head_q, head_d;
   CkptId  tail_q, tail_d;
   CkptCnt count_q, count_d;
   FreePtr snap_q [NUM_CKPTS];
   logic   retire_eff;
   CkptId  live_off;

   assign ckpt_full    = (count_q == CkptCnt'(NUM_CKPTS));
   assign ckpt_ack     = rst_n && ckpt_req && !ckpt_full && !recover_valid;
   assign ckpt_id      = tail_q;
   assign recover_head = snap_q[recover_id];
   // A retire on an empty ring is dropped rather than underflowing the count.
   assign retire_eff   = ckpt_retire && (count_q != '0);
   assign live_off     = recover_id - head_q;

   // Next-state for ring pointers; recovery discards the recovering slot and all younger.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (retire_eff) begin
         head_d = head_q + 1'b1;
      end
      if (recover_valid) begin
         tail_d  = recover_id;
         count_d = {1'b0, CkptId'(recover_id - head_d)};
      end else begin
         if (ckpt_ack) begin
            tail_d = tail_q + 1'b1;
         end
         count_d = count_q + CkptCnt'(ckpt_ack) - CkptCnt'(retire_eff);
      end
   end

   // Ring state and snapshot storage, synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(NUM_CKPTS); i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (ckpt_ack) begin
            snap_q[tail_q] <= snap_head;
         end
      end
   end

   a_retire_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
      ckpt_retire |-> (count_q != '0));
   a_recover_live : assert property (@(posedge clk) disable iff (!rst_n)
      recover_valid |-> (CkptCnt'(live_off) < count_q));
   a_recover_not_retiring : assert property (@(posedge clk) disable iff (!rst_n)
      (recover_valid && ckpt_retire) |-> (recover_id != head_q));

endmodule

// File: rtl/phys_reg_allocator.sv
// Physical register pool: free FIFO, per-preg ready bits, checkpointed head recovery.
module phys_reg_allocator
   import phys_reg_allocator_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_req,
   output logic                     alloc_grant,
   output PhysReg                   alloc_preg,
   input  logic                     release_valid,
   input  PhysReg                   release_preg,
   input  logic                     wb_valid,
   input  PhysReg                   wb_preg,
   output logic [NUM_PHYS_REGS-1:0] preg_ready,
   output FreePtr                   free_count,
   input  logic                     ckpt_req,
   output logic                     ckpt_ack,
   output CkptId                    ckpt_id,
   output logic                     ckpt_full,
   input  logic                     ckpt_retire,
   input  logic                     recover_valid,
   input  CkptId                    recover_id,
   output logic                     stall
);

   PhysReg                   fifo_q [FREE_DEPTH];
   FreePtr                   head_q, head_d;
   FreePtr                   tail_q, tail_d;
   FreePtr                   head_post_grant;
   FreePtr                   recover_head;
   logic [NUM_PHYS_REGS-1:0] ready_q, ready_d;
   logic                     release_ok;

   assign free_count      = tail_q - head_q;
   assign alloc_grant     = rst_n && alloc_req && (free_count != '0) && !recover_valid;
   assign alloc_preg      = fifo_q[head_q[FIFO_IDX_W-1:0]];
   // A release into a full FIFO would overwrite a live entry; it is dropped.
   assign release_ok      = release_valid && (free_count != FreePtr'(FREE_DEPTH));
   // Checkpoints capture the head after this cycle's grant.
   assign head_post_grant = head_q + FreePtr'(alloc_grant);
   assign preg_ready      = ready_q;
   assign stall           = rst_n && ((alloc_req && !alloc_grant) || (ckpt_req && !ckpt_ack));

   phys_reg_allocator_ckpt_ring u_ckpt_ring (
      .clk           (clk),
      .rst_n         (rst_n),
      .ckpt_req      (ckpt_req),
      .ckpt_retire   (ckpt_retire),
      .recover_valid (recover_valid),
      .recover_id    (recover_id),
      .snap_head     (head_post_grant),
      .ckpt_ack      (ckpt_ack),
      .ckpt_id       (ckpt_id),
      .ckpt_full     (ckpt_full),
      .recover_head  (recover_head)
   );

   // Pointer and ready-vector next state; grant clears ready after wb sets it.
   always_comb begin
      head_d  = recover_valid ? recover_head : head_post_grant;
      tail_d  = tail_q + FreePtr'(release_ok);
      ready_d = ready_q;
      if (wb_valid) begin
         ready_d[wb_preg] = 1'b1;
      end
      if (alloc_grant) begin
         ready_d[alloc_preg] = 1'b0;
      end
   end

   // Free FIFO storage, pointers and ready bits, synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= FreePtr'(FREE_DEPTH);
         ready_q <= '1;
         for (int i = 0; i < int'(FREE_DEPTH); i++) begin
            fifo_q[i] <= PhysReg'(int'(NUM_ARCH_REGS) + i);
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         ready_q <= ready_d;
         if (release_ok) begin
            fifo_q[tail_q[FIFO_IDX_W-1:0]] <= release_preg;
         end
      end
   end

   a_release_not_full : assert property (@(posedge clk) disable iff (!rst_n)
      release_valid |-> (free_count != FreePtr'(FREE_DEPTH)));
   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      free_count <= FreePtr'(FREE_DEPTH));

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Directed bench for phys_reg_allocator with hand-computed expectations.
module tb_phys_reg_allocator;
   import phys_reg_allocator_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alloc_req;
   logic        alloc_grant;
   PhysReg      alloc_preg;
   logic        release_valid;
   PhysReg      release_preg;
   logic        wb_valid;
   PhysReg      wb_preg;
   logic [63:0] preg_ready;
   FreePtr      free_count;
   logic        ckpt_req;
   logic        ckpt_ack;
   CkptId       ckpt_id;
   logic        ckpt_full;
   logic        ckpt_retire;
   logic        recover_valid;
   CkptId       recover_id;
   logic        stall;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   phys_reg_allocator dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_req     (alloc_req),
      .alloc_grant   (alloc_grant),
      .alloc_preg    (alloc_preg),
      .release_valid (release_valid),
      .release_preg  (release_preg),
      .wb_valid      (wb_valid),
      .wb_preg       (wb_preg),
      .preg_ready    (preg_ready),
      .free_count    (free_count),
      .ckpt_req      (ckpt_req),
      .ckpt_ack      (ckpt_ack),
      .ckpt_id       (ckpt_id),
      .ckpt_full     (ckpt_full),
      .ckpt_retire   (ckpt_retire),
      .recover_valid (recover_valid),
      .recover_id    (recover_id),
      .stall         (stall)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      alloc_req     = 1'b0;
      release_valid = 1'b0;
      release_preg  = '0;
      wb_valid      = 1'b0;
      wb_preg       = '0;
      ckpt_req      = 1'b0;
      ckpt_retire   = 1'b0;
      recover_valid = 1'b0;
      recover_id    = '0;
   endtask

   // Inputs change and outputs are sampled only around the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic grant_n(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         idle();
         alloc_req = 1'b1;
         #1;
         check_eq("grant", 64'(alloc_grant), 64'd1);
         check_eq("alloc_preg", 64'(alloc_preg), 64'(first + i));
         tick();
      end
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst_n = 1'b0;
      tick();

      // Requests during reset are ignored.
      alloc_req = 1'b1;
      ckpt_req  = 1'b1;
      #1;
      check_eq("rst_grant", 64'(alloc_grant), 64'd0);
      check_eq("rst_ack", 64'(ckpt_ack), 64'd0);
      check_eq("rst_stall", 64'(stall), 64'd0);
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      check_eq("rst_free_count", 64'(free_count), 64'd32);
      check_eq("rst_ready", preg_ready, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("rst_ckpt_full", 64'(ckpt_full), 64'd0);
      check_eq("rst_alloc_preg", 64'(alloc_preg), 64'd32);
      check_eq("rst_ckpt_id", 64'(ckpt_id), 64'd0);
      check_eq("rst_idle_grant", 64'(alloc_grant), 64'd0);

      // Drain the pool.
      grant_n(32, 32);
      alloc_req = 1'b1;
      #1;
      check_eq("empty_grant", 64'(alloc_grant), 64'd0);
      check_eq("empty_stall", 64'(stall), 64'd1);
      check_eq("empty_free_count", 64'(free_count), 64'd0);
      check_eq("empty_ready", preg_ready, 64'h0000_0000_FFFF_FFFF);
      tick();

      // Release at empty is not bypassed to a same-cycle grant.
      alloc_req     = 1'b1;
      release_valid = 1'b1;
      release_preg  = 6'd5;
      #1;
      check_eq("nobypass_grant", 64'(alloc_grant), 64'd0);
      tick();
      idle();
      alloc_req = 1'b1;
      #1;
      check_eq("rel_free_count", 64'(free_count), 64'd1);
      check_eq("rel_grant", 64'(alloc_grant), 64'd1);
      check_eq("rel_preg", 64'(alloc_preg), 64'd5);
      tick();
      idle();
      #1;
      check_eq("rel_after_count", 64'(free_count), 64'd0);
      check_eq("rel_ready5", 64'(preg_ready[5]), 64'd0);

      // Checkpoint then recover the head.
      do_reset();
      grant_n(3, 32);
      ckpt_req = 1'b1;
      #1;
      check_eq("ck_ack", 64'(ckpt_ack), 64'd1);
      check_eq("ck_id", 64'(ckpt_id), 64'd0);
      tick();
      grant_n(4, 35);
      #1;
      check_eq("ck_free25", 64'(free_count), 64'd25);
      recover_valid = 1'b1;
      recover_id    = 2'd0;
      alloc_req     = 1'b1;
      ckpt_req      = 1'b1;
      #1;
      check_eq("rec_grant", 64'(alloc_grant), 64'd0);
      check_eq("rec_ack", 64'(ckpt_ack), 64'd0);
      check_eq("rec_stall", 64'(stall), 64'd1);
      tick();
      idle();
      #1;
      check_eq("rec_free_count", 64'(free_count), 64'd29);
      check_eq("rec_alloc_preg", 64'(alloc_preg), 64'd35);
      check_eq("rec_ckpt_id", 64'(ckpt_id), 64'd0);
      check_eq("rec_ckpt_full", 64'(ckpt_full), 64'd0);

      // Fill the ring, overflow, retire, wrap.
      for (int i = 0; i < 4; i++) begin
         idle();
         ckpt_req = 1'b1;
         #1;
         check_eq("fill_ack", 64'(ckpt_ack), 64'd1);
         check_eq("fill_id", 64'(ckpt_id), 64'(i));
         tick();
      end
      idle();
      #1;
      check_eq("full_flag", 64'(ckpt_full), 64'd1);
      ckpt_req = 1'b1;
      #1;
      check_eq("full_ack", 64'(ckpt_ack), 64'd0);
      check_eq("full_stall", 64'(stall), 64'd1);
      tick();
      idle();
      ckpt_retire = 1'b1;
      tick();
      idle();
      #1;
      check_eq("retire_full", 64'(ckpt_full), 64'd0);
      ckpt_req = 1'b1;
      #1;
      check_eq("wrap_ack", 64'(ckpt_ack), 64'd1);
      check_eq("wrap_id", 64'(ckpt_id), 64'd0);
      tick();
      idle();
      #1;
      check_eq("wrap_full", 64'(ckpt_full), 64'd1);

      // Ring head=1, four live; recovering slot 3 keeps slots 1 and 2.
      recover_valid = 1'b1;
      recover_id    = 2'd3;
      tick();
      idle();
      #1;
      check_eq("trunc_id", 64'(ckpt_id), 64'd3);
      check_eq("trunc_full", 64'(ckpt_full), 64'd0);
      check_eq("trunc_preg", 64'(alloc_preg), 64'd35);
      check_eq("trunc_count", 64'(free_count), 64'd29);
      ckpt_req = 1'b1;
      #1;
      check_eq("trunc_ack3", 64'(ckpt_id), 64'd3);
      tick();
      #1;
      check_eq("trunc_ack0", 64'(ckpt_id), 64'd0);
      check_eq("trunc_ack0_ok", 64'(ckpt_ack), 64'd1);
      tick();
      idle();
      #1;
      check_eq("trunc_refull", 64'(ckpt_full), 64'd1);

      // Snapshot taken with a same-cycle grant; release during recovery still applies.
      do_reset();
      alloc_req = 1'b1;
      ckpt_req  = 1'b1;
      #1;
      check_eq("snap_ack", 64'(ckpt_ack), 64'd1);
      check_eq("snap_grant", 64'(alloc_grant), 64'd1);
      tick();
      grant_n(2, 33);
      recover_valid = 1'b1;
      recover_id    = 2'd0;
      release_valid = 1'b1;
      release_preg  = 6'd7;
      tick();
      idle();
      #1;
      check_eq("snap_preg", 64'(alloc_preg), 64'd33);
      check_eq("snap_count", 64'(free_count), 64'd32);

      // Ready bits: grant clears, wb sets, grant beats same-cycle wb.
      do_reset();
      grant_n(1, 32);
      #1;
      check_eq("rdy32_clr", 64'(preg_ready[32]), 64'd0);
      check_eq("rdy33_set", 64'(preg_ready[33]), 64'd1);
      wb_valid = 1'b1;
      wb_preg  = 6'd32;
      tick();
      idle();
      #1;
      check_eq("rdy32_wb", 64'(preg_ready[32]), 64'd1);
      alloc_req = 1'b1;
      wb_valid  = 1'b1;
      wb_preg   = 6'd33;
      #1;
      check_eq("rdy_race_preg", 64'(alloc_preg), 64'd33);
      tick();
      idle();
      #1;
      check_eq("rdy33_race", 64'(preg_ready[33]), 64'd0);

      // Mid-operation reset.
      do_reset();
      grant_n(10, 32);
      ckpt_req = 1'b1;
      tick();
      tick();
      idle();
      rst_n     = 1'b0;
      alloc_req = 1'b1;
      ckpt_req  = 1'b1;
      #1;
      check_eq("mid_rst_grant", 64'(alloc_grant), 64'd0);
      check_eq("mid_rst_ack", 64'(ckpt_ack), 64'd0);
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      check_eq("mid_free_count", 64'(free_count), 64'd32);
      check_eq("mid_alloc_preg", 64'(alloc_preg), 64'd32);
      check_eq("mid_ckpt_full", 64'(ckpt_full), 64'd0);
      check_eq("mid_ckpt_id", 64'(ckpt_id), 64'd0);
      check_eq("mid_ready", preg_ready, 64'hFFFF_FFFF_FFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
